// File: rtl/bus_line_fill_pkg.sv
// Shared types and constants for the bus_line_fill miss/writeback engine.
package bus_line_fill_pkg;

  localparam int LINE_BYTES  = 64;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int BEATS       = 8;
  localparam int BEAT_W      = 64;
  localparam int TAG_W       = 13;
  localparam int LINE_W      = BEATS * BEAT_W;

  localparam logic [TAG_W-1:0] TAG_READ  = 13'h1100;
  localparam logic [TAG_W-1:0] TAG_WRITE = 13'h1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic [LINE_W-1:0] line_t;
  typedef logic [2:0]        beat_idx_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? (v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/bus_line_fill_assembler.sv
// Line datapath: beat counter, read-beat shift-in register and write-beat select mux.
module line_fill_assembler
  import bus_line_fill_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              cnt_clr,
  input  logic              wr_step,
  input  logic              rd_store,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic              last_beat,
  output logic [BEAT_W-1:0] wr_beat,
  output logic [LINE_W-1:0] rd_line
);

  beat_idx_t cnt_r;
  line_t     wr_line_r;
  line_t     rd_line_r;

  // Beat counter; wraps 7->0 on its own so it is back at 0 after every line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= 3'd0;
    end else if (cnt_clr) begin
      cnt_r <= 3'd0;
    end else if (wr_step || rd_store) begin
      cnt_r <= cnt_r + 3'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Writeback line captured on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_line_r <= '0;
    end else if (load) begin
      wr_line_r <= wr_line;
    end else begin
      wr_line_r <= wr_line_r;
    end
  end

  // Read line assembly: each good beat lands in slot cnt_r.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_line_r <= '0;
    end else if (rd_store) begin
      rd_line_r[{cnt_r, 6'd0} +: BEAT_W] <= rd_beat;
    end else begin
      rd_line_r <= rd_line_r;
    end
  end

  assign last_beat = (cnt_r == 3'd7);
  assign wr_beat   = wr_line_r[{cnt_r, 6'd0} +: BEAT_W];
  assign rd_line   = rd_line_r;

endmodule

// File: rtl/bus_line_fill.sv
// L1 miss/writeback engine: one line request -> bus reqcyc/respcyc beats -> done pulse.
// Optional performance counters are built when LINE_FILL_PERF_EN is defined.
module bus_line_fill
  import bus_line_fill_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fill_req_valid,
  output logic              fill_req_ready,
  input  logic              fill_req_write,
  input  logic [ADDR_W-1:0] fill_req_addr,
  input  logic [LINE_W-1:0] fill_req_line,
  output logic              fill_done,
  output logic              fill_done_write,
  output logic [ADDR_W-1:0] fill_resp_addr,
  output logic [LINE_W-1:0] fill_resp_line,
  output logic              bus_reqcyc,
  input  logic              bus_reqack,
  output logic [BEAT_W-1:0] bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_respcyc,
  output logic              bus_respack,
  input  logic [BEAT_W-1:0] bus_resp,
  input  logic [TAG_W-1:0]  bus_resptag
`ifdef LINE_FILL_PERF_EN
  ,
  output logic [31:0]       perf_fills,
  output logic [31:0]       perf_writebacks,
  output logic [31:0]       perf_wait_cycles,
  output logic [15:0]       perf_bad_tags
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);

  state_t            state_r;
  state_t            state_s;
  logic              write_r;
  logic [ADDR_W-1:0] addr_r;
  logic              accept_s;
  logic              good_beat_s;
  logic              last_beat_s;
  logic [BEAT_W-1:0] wr_beat_s;

  assign accept_s    = fill_req_valid && (state_r == IDLE);
  assign good_beat_s = (state_r == RDATA) && bus_respcyc && (bus_resptag == TAG_READ);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (fill_req_valid) state_s = REQ;   else state_s = IDLE;
      REQ:     if (bus_reqack) state_s = write_r ? WDATA : RDATA; else state_s = REQ;
      WDATA:   if (last_beat_s) state_s = DONE;     else state_s = WDATA;
      RDATA:   if (good_beat_s && last_beat_s) state_s = DONE; else state_s = RDATA;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    fill_req_ready  = 1'b0;
    fill_done       = 1'b0;
    fill_done_write = 1'b0;
    bus_reqcyc      = 1'b0;
    bus_req         = '0;
    bus_reqtag      = '0;
    bus_respack     = 1'b0;
    case (state_r)
      IDLE: fill_req_ready = 1'b1;
      REQ: begin
        bus_reqcyc = 1'b1;
        bus_req    = BEAT_W'(addr_r);
        bus_reqtag = write_r ? TAG_WRITE : TAG_READ;
      end
      WDATA: begin
        bus_reqcyc = 1'b1;
        bus_req    = wr_beat_s;
        bus_reqtag = TAG_WRITE;
      end
      RDATA: bus_respack = bus_respcyc;
      DONE: begin
        fill_done       = 1'b1;
        fill_done_write = write_r;
      end
      default: fill_req_ready = 1'b0;
    endcase
  end

  // Request capture; the line offset is dropped here so every later use is aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_r <= 1'b0;
      addr_r  <= '0;
    end else if (accept_s) begin
      write_r <= fill_req_write;
      addr_r  <= fill_req_addr & ALIGN_MASK;
    end else begin
      write_r <= write_r;
      addr_r  <= addr_r;
    end
  end

  assign fill_resp_addr = addr_r;

  line_fill_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_s),
    .wr_line   (fill_req_line),
    .cnt_clr   ((state_r == REQ) && bus_reqack),
    .wr_step   (state_r == WDATA),
    .rd_store  (good_beat_s),
    .rd_beat   (bus_resp),
    .last_beat (last_beat_s),
    .wr_beat   (wr_beat_s),
    .rd_line   (fill_resp_line)
  );

`ifdef LINE_FILL_PERF_EN
  logic bad_beat_s;
  logic wait_s;

  assign bad_beat_s = (state_r == RDATA) && bus_respcyc && (bus_resptag != TAG_READ);
  assign wait_s     = ((state_r == REQ) && !bus_reqack) || ((state_r == RDATA) && !bus_respcyc);

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fills       <= 32'd0;
      perf_writebacks  <= 32'd0;
      perf_wait_cycles <= 32'd0;
      perf_bad_tags    <= 16'd0;
    end else begin
      perf_fills       <= sat_inc32(perf_fills, (state_r == DONE) && !write_r);
      perf_writebacks  <= sat_inc32(perf_writebacks, (state_r == DONE) && write_r);
      perf_wait_cycles <= sat_inc32(perf_wait_cycles, wait_s);
      perf_bad_tags    <= sat_inc16(perf_bad_tags, bad_beat_s);
    end
  end
`endif

endmodule
